if_fetch: RTL
=============

Name: if_fetch

Overview:
- Instruction-fetch stage of the 5-stage RV32I pipeline, directly upstream of the IF/ID pipeline register.
- Owns the PC and fetches each 32-bit instruction as four little-endian bytes over the shared byte-wide memory port.
- Presents the assembled word and its PC to IF/ID, honouring the pipeline staller, EX-stage branch redirects, and memory-port arbitration against the MEM stage.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset

Ports:
dclk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-low (0 = reset)
rdy  input  1  global ready; 0 = pause
stl_STALLER_i  input  2  staller code: 2'b00 Go, 2'b01 Stall, 2'b10 Bubble
br_EX_i  input  1  branch/jump taken, 1-cycle pulse from EX
br_addr_EX_i  input  32  redirect target
mem_busy_i  input  1  memory port granted to MEM stage this cycle
mem_data_i  input  8  byte returned for the request issued the previous cycle
mem_addr_o  output  32  byte address (combinational)
mem_re_o  output  1  read request (combinational)
inst_IF_o  output  32  assembled instruction to IF/ID (registered)
pc_o  output  32  PC of current fetch/instruction (registered)
inst_valid_o  output  1  inst_IF_o holds a complete instruction (registered)

Behaviour:
- Reset:
  - rst==0 at a rising edge gives pc_o=RESET_PC, inst_IF_o=0, inst_valid_o=0, byte buffer=0, state=A0.
  - Reset overrides rdy, branch, stall and busy.
- States: A0, B1, B2, B3, B4, HOLD.
- Memory interface:
  - mem_re_o = rdy & ~mem_busy_i & state∈{A0,B1,B2,B3}.
  - mem_addr_o = pc_o + {0,1,2,3} for A0/B1/B2/B3 respectively; 0 otherwise.
  - Memory read latency is exactly 1 cycle.
- Fetch sequence, with no busy, no branch and rdy=1:
  - A0: issue pc+0.
  - B1: capture byte0 into buf[7:0], issue pc+1.
  - B2: capture byte1 into buf[15:8], issue pc+2.
  - B3: capture byte2 into buf[23:16], issue pc+3.
  - B4: on this edge inst_IF_o <= {mem_data_i, buf[23:0]}, inst_valid_o <= 1, next state HOLD.
  - First valid cycle is 5 cycles after A0.
- Consumption, in HOLD:
  - If stl_STALLER_i==Go, at the next edge pc_o <= pc_o+4 (mod 2^32), inst_IF_o <= 0, inst_valid_o <= 0, state <= A0. IF/ID latches the word on that same edge.
  - Stall or Bubble: hold all registers. Bubble is treated as hold because IF/ID discards its content.
- Outside HOLD, inst_IF_o is 0 and IF/ID sees ZeroWord bubbles.
- Branch (br_EX_i==1 with rdy==1, any state):
  - Next edge: pc_o <= br_addr_EX_i, state <= A0, inst_valid_o <= 0, inst_IF_o <= 0, buf discarded.
  - Branch takes priority over Stall/Bubble and over mem_busy_i.
- mem_busy_i==1 in A0..B4, no branch:
  - Partial fetch is discarded; state <= A0; pc_o held.
  - Fetch restarts at pc+0 in the first non-busy cycle.
  - In HOLD, busy has no effect.
- rdy==0:
  - mem_re_o=0.
  - In A0..B4: state <= A0, pc_o held, partial discarded.
  - In HOLD: all registers held.
  - br_EX_i is ignored while rdy==0; the staller re-presents it.
- Priority, highest first: reset, rdy low, branch, busy, stall, normal advance.
- No misalignment check: pc_o[1:0] follows br_addr_EX_i as given.

Test Plan:
1. Reset then first fetch, with bytes 0x13,0x05,0x10,0x00 at addresses 0..3 and rst raised at cycle 0 -> mem_addr_o 0,1,2,3 in cycles 0-3; cycle 5 inst_valid_o=1, inst_IF_o=32'h00100513, pc_o=0; with Go, cycle 6 pc_o=4, mem_addr_o=4, inst_IF_o=0.
2. Stall hold: in HOLD, stl_STALLER_i=2'b01 for 3 cycles, then 2'b10 for 1 cycle -> inst_IF_o/pc_o unchanged and mem_re_o=0 throughout; on Go, pc_o advances to 4 on the following edge.
3. Branch mid-fetch: br_EX_i=1, br_addr_EX_i=32'h100 while in B2 -> next cycle state A0, mem_addr_o=32'h100, inst_valid_o=0; word at 0x100 valid 5 cycles later with pc_o=32'h100.
4. Branch and Stall in the same HOLD cycle, target 32'h40 -> pc_o=32'h40, inst_valid_o=0 next cycle; the stall does not block the redirect.
5. mem_busy_i=1 for 2 cycles during B3 -> mem_re_o=0 while busy; first free cycle mem_addr_o=pc+0; valid arrives 5 cycles after busy drops; assembled word correct.
6. rst=0 during B2, and rdy=0 during B3 of a separate fetch -> reset gives pc_o=RESET_PC and all outputs 0; rdy case restarts at pc+0 with pc_o unchanged. PC wrap: pc_o=32'hFFFFFFFC consumed -> pc_o=0.

Source files
------------

// File: rtl/if_fetch.sv
// if_fetch: RV32I instruction-fetch stage.
// Owns the PC and fetches each 32-bit word as four little-endian bytes over
// the shared byte-wide memory port (1-cycle read latency). It presents the
// assembled word and its PC to IF/ID and honours stalls, EX-stage redirects
// and memory-port arbitration against the MEM stage.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        dclk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [1:0]  stl_STALLER_i,
    input  logic        br_EX_i,
    input  logic [31:0] br_addr_EX_i,
    input  logic        mem_busy_i,
    input  logic [7:0]  mem_data_i,
    output logic [31:0] mem_addr_o,
    output logic        mem_re_o,
    output logic [31:0] inst_IF_o,
    output logic [31:0] pc_o,
    output logic        inst_valid_o
);

    // A0 issues byte 0. Bx captures byte x-1 and issues byte x (up to B3).
    // B4 captures byte 3 and completes the word. HOLD presents it to IF/ID.
    typedef enum logic [2:0] {
        S_A0   = 3'd0,
        S_B1   = 3'd1,
        S_B2   = 3'd2,
        S_B3   = 3'd3,
        S_B4   = 3'd4,
        S_HOLD = 3'd5
    } state_t;

    localparam logic [1:0] STL_GO = 2'b00;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [23:0] r_buf;
    logic [31:0] r_inst;
    logic        r_valid;

    logic        w_fetching;
    logic        w_redirect;
    logic        w_step;
    logic        w_consume;
    logic        w_issue;
    logic [31:0] w_offset;

    // Event decode. rdy low masks everything, so a branch seen while paused
    // is dropped here and the staller re-presents it later.
    assign w_fetching = (r_state != S_HOLD);
    assign w_redirect = rdy & br_EX_i;
    assign w_step     = rdy & ~br_EX_i & ~mem_busy_i & w_fetching;
    assign w_consume  = rdy & ~br_EX_i & (r_state == S_HOLD) &
                        (stl_STALLER_i == STL_GO);

    // State register.
    always_ff @(posedge dclk) begin
        if (!rst) begin
            r_state <= S_A0;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic. Any interruption of a partial fetch (pause, busy
    // port, redirect) restarts it at byte 0; HOLD only leaves on Go or
    // a redirect.
    always_comb begin
        w_state_nxt = r_state;
        if (!rdy) begin
            if (w_fetching) begin
                w_state_nxt = S_A0;
            end
        end else if (br_EX_i) begin
            w_state_nxt = S_A0;
        end else if (w_fetching && mem_busy_i) begin
            w_state_nxt = S_A0;
        end else begin
            case (r_state)
                S_A0:    w_state_nxt = S_B1;
                S_B1:    w_state_nxt = S_B2;
                S_B2:    w_state_nxt = S_B3;
                S_B3:    w_state_nxt = S_B4;
                S_B4:    w_state_nxt = S_HOLD;
                S_HOLD:  w_state_nxt = (stl_STALLER_i == STL_GO) ? S_A0 : S_HOLD;
                default: w_state_nxt = S_A0;
            endcase
        end
    end

    // Output logic: which byte of the current word the state requests.
    always_comb begin
        w_issue  = 1'b0;
        w_offset = 32'd0;
        case (r_state)
            S_A0: begin w_issue = 1'b1; w_offset = 32'd0; end
            S_B1: begin w_issue = 1'b1; w_offset = 32'd1; end
            S_B2: begin w_issue = 1'b1; w_offset = 32'd2; end
            S_B3: begin w_issue = 1'b1; w_offset = 32'd3; end
            default: begin w_issue = 1'b0; w_offset = 32'd0; end
        endcase
    end

    assign mem_re_o   = rdy & ~mem_busy_i & w_issue;
    assign mem_addr_o = w_issue ? (r_pc + w_offset) : 32'd0;

    // Byte buffer: collect bytes 0..2 while the fetch advances. Any stalled
    // or aborted fetch cycle throws away the partial word.
    always_ff @(posedge dclk) begin
        if (!rst) begin
            r_buf <= 24'd0;
        end else if (w_step) begin
            case (r_state)
                S_A0:    r_buf <= 24'd0;
                S_B1:    r_buf[7:0]   <= mem_data_i;
                S_B2:    r_buf[15:8]  <= mem_data_i;
                S_B3:    r_buf[23:16] <= mem_data_i;
                default: r_buf <= r_buf;
            endcase
        end else if (w_fetching) begin
            r_buf <= 24'd0;
        end
    end

    // PC and presented word. Redirect beats consumption. The word becomes
    // valid only on the B4 edge and is zeroed whenever HOLD is left, so
    // IF/ID sees ZeroWord bubbles outside HOLD.
    always_ff @(posedge dclk) begin
        if (!rst) begin
            r_pc    <= RESET_PC;
            r_inst  <= 32'd0;
            r_valid <= 1'b0;
        end else if (w_redirect) begin
            r_pc    <= br_addr_EX_i;
            r_inst  <= 32'd0;
            r_valid <= 1'b0;
        end else if (w_consume) begin
            r_pc    <= r_pc + 32'd4;
            r_inst  <= 32'd0;
            r_valid <= 1'b0;
        end else if (w_step && (r_state == S_B4)) begin
            r_inst  <= {mem_data_i, r_buf};
            r_valid <= 1'b1;
        end
    end

    assign pc_o         = r_pc;
    assign inst_IF_o    = r_inst;
    assign inst_valid_o = r_valid;

endmodule
